fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Downstream consumer of the dual/single-clock block-RAM FIFO primitive wrapper in the SoC.
- The FIFO runs in standard mode (not first-word-fall-through): data appears a fixed READ_LATENCY cycles after rd_en.
- The block drives the FIFO read port and delivers the words as a valid/ready stream, sustaining one word per cycle, using a small credit-controlled skid buffer.
- It sits in the FIFO read-clock domain, between the FIFO and an AXI-stream-like consumer (UART/SD/Ethernet datapaths).

Parameters:
- WIDTH, 36, data width; must match the FIFO width (9, 18 or 36).
- READ_LATENCY, 2, cycles from fifo_rd_en_o to valid fifo_dout_i; legal values are 1 (sync FIFO, no output register) and 2 (async FIFO, DO_REG=1).

Ports:
- clk_i  in  1  clock; the FIFO read clock.
- rst_ni  in  1  reset. Synchronous, active-low.
- flush_i  in  1  synchronous drop of all buffered and in-flight words.
- fifo_empty_i  in  1  FIFO EMPTY flag.
- fifo_rderr_i  in  1  FIFO RDERR flag.
- fifo_dout_i  in  WIDTH  FIFO read data.
- fifo_rd_en_o  out  1  FIFO RDEN.
- m_data_o  out  WIDTH  stream data.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- count_o  out  2  skid-buffer occupancy (0..READ_LATENCY+1).
- rd_err_o  out  1  sticky error flag.

Behaviour:
Internal structure:
- DEPTH = READ_LATENCY+1; circular buffer mem[DEPTH], with wr_ptr, rd_ptr and occ counter.
- Shift register inflight[READ_LATENCY] tracks outstanding reads; n_inflight is the popcount of inflight.

Handshake and buffer:
- pop = m_valid_o & m_ready_i.
- m_valid_o = (occ != 0); m_data_o = mem[rd_ptr]. Both come from registers; there is no combinational path from fifo_dout_i to the stream.
- fifo_rd_en_o = rst_ni & !flush_i & !fifo_empty_i & (occ + n_inflight - pop < DEPTH). This is combinational. The credit check guarantees no buffer overflow.
- The block never asserts fifo_rd_en_o while fifo_empty_i=1, so a read underflow is impossible by construction.
- inflight shifts each cycle, with fifo_rd_en_o entering at stage 0.
- When the last stage is 1, fifo_dout_i is written to mem[wr_ptr] at the clock edge and wr_ptr advances.

Latency and throughput:
- Read issued in cycle t: data is captured at the end of cycle t+READ_LATENCY-1+1, i.e. the word is visible on the stream in cycle t+READ_LATENCY+1. First-word latency from the EMPTY deassert cycle is READ_LATENCY+1 cycles.
- Steady state with m_ready_i=1 and FIFO non-empty: fifo_rd_en_o=1 every cycle and one word per cycle on the stream.

Ordering and pointers:
- Words leave in FIFO order; there is no reordering or duplication.
- occ update: occ += capture - pop, evaluated simultaneously (capture and pop in the same cycle leaves occ unchanged).
- Pointers wrap modulo DEPTH; DEPTH=3 is not a power of two, so the wrap is explicit.

Backpressure:
- With m_ready_i=0, reads stop once occ + n_inflight = DEPTH. All in-flight words still land; the buffer is never overwritten.
- While stalled, m_data_o is held stable.

Flush:
- In the flush_i cycle, fifo_rd_en_o=0. At the edge: occ, pointers and inflight are cleared, so words still in the FIFO output pipeline are discarded when they arrive.
- m_valid_o=0 in the following cycle.
- Words already popped from the FIFO are lost by design.

Errors:
- rd_err_o is set on fifo_rderr_i=1 and cleared only by reset.
- The FIFO's own empty/rd_en race is not masked; rd_err_o reports it.

Reset (rst_ni=0 at the edge):
- fifo_rd_en_o=0 combinationally.
- m_valid_o=0, count_o=0, rd_err_o=0, pointers=0, inflight=0. mem contents are not reset.
- Reset mid-burst behaves identically to flush and also clears rd_err_o.

Decomposition:
- Package soc_fifo_pkg holds:
  - localparam max latency = 2;
  - function clog2_depth;
  - typedef of the occupancy counter.
- One sub-module, stream_skid_buffer (the circular mem/pointer/occ logic with push/pop and a level output).
- The top level holds the credit check, the inflight shift register, flush and the error flag.

Test Plan:
- L=2, preload FIFO with 0x1..0x8, m_ready_i=1 -> rd_en high 8 consecutive cycles; m_valid_o high 8 consecutive cycles starting 3 cycles after first rd_en, data 0x1..0x8 in order; count_o ≤1.
- L=2, 8 words queued, m_ready_i=0 -> exactly 3 rd_en pulses, count_o=3, m_data_o=0x1 held; raise m_ready_i -> 0x1..0x8 delivered with no gap after the first pop.
- L=1, m_ready_i toggling 1010… with 6 words -> count_o never exceeds 2; all 6 words received once, in order.
- L=2, flush_i pulsed 1 cycle after 2 rd_en issued (words 0xA, 0xB in flight) -> 0xA/0xB never appear; next word 0xC appears normally; count_o=0 after flush.
- fifo_empty_i held 1 for 20 cycles -> fifo_rd_en_o never 1; m_valid_o=0. Inject fifo_rderr_i pulse -> rd_err_o=1 sticky until rst_ni low for 1 cycle.
- rst_ni low in mid-stream with count_o=2 -> next cycle m_valid_o=0, count_o=0, rd_en=0 during reset; after release, remaining FIFO words stream normally.

Source files
------------

// File: rtl/soc_fifo_pkg.sv
// Shared types and helpers for the FIFO read-side stream logic.
package soc_fifo_pkg;

  localparam int MAX_READ_LATENCY = 2;

  // Skid-buffer occupancy; wide enough for MAX_READ_LATENCY + 1 entries.
  typedef logic [1:0] occ_t;

  function automatic int clog2_depth(input int depth);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= depth) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Circular buffer of DEPTH words with push/pop and a registered level.
module stream_skid_buffer
  import soc_fifo_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output occ_t             level_o
);

  localparam int PTR_W = clog2_depth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  occ_t             occ_q, occ_d;

  // DEPTH need not be a power of two, so the wrap is explicit.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    occ_d = occ_q + occ_t'(push_i) - occ_t'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (occ_q != '0);
  assign level_o = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drives a standard-mode FIFO read port and presents the words as a
// valid/ready stream through a credit-controlled skid buffer.
module fifo_stream_reader
  import soc_fifo_pkg::*;
#(
  parameter int WIDTH        = 36,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_rderr_i,
  input  logic [WIDTH-1:0] fifo_dout_i,
  output logic             fifo_rd_en_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [1:0]       count_o,
  output logic             rd_err_o
);

  localparam int DEPTH = READ_LATENCY + 1;
  localparam int SUM_W = clog2_depth(2 * MAX_READ_LATENCY + 2);

  logic [READ_LATENCY-1:0] inflight_q, inflight_d;
  logic [SUM_W-1:0]        n_inflight, credit_sum;
  logic                    rd_en, pop, capture, valid, rd_err_q;
  occ_t                    level;

  assign pop     = valid & m_ready_i;
  assign capture = inflight_q[READ_LATENCY-1];

  always_comb begin
    n_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      n_inflight = n_inflight + SUM_W'(inflight_q[i]);
    end
  end

  // Every outstanding read must have a free slot waiting when it lands.
  assign credit_sum = SUM_W'(level) + n_inflight - SUM_W'(pop);
  assign rd_en      = rst_ni & ~flush_i & ~fifo_empty_i & (credit_sum < SUM_W'(DEPTH));
  assign inflight_d = READ_LATENCY'({inflight_q, rd_en});

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) inflight_q <= '0;
    else                    inflight_q <= inflight_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)           rd_err_q <= 1'b0;
    else if (fifo_rderr_i) rd_err_q <= 1'b1;
  end

  stream_skid_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (flush_i),
    .push_i      (capture),
    .push_data_i (fifo_dout_i),
    .pop_i       (pop),
    .data_o      (m_data_o),
    .valid_o     (valid),
    .level_o     (level)
  );

  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = valid;
  assign count_o      = level;
  assign rd_err_o     = rd_err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: two readers (latency 2 and 1) fed by simple FIFO models.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic flush_a = 1'b0;
  logic ready_a = 1'b0;
  logic ready_b = 1'b0;
  logic rderr_a = 1'b0;
  logic tog_b   = 1'b0;

  // FIFO model A: two-cycle read latency
  logic [35:0] fa_mem [0:63];
  int          fa_wr = 0;
  int          fa_rd = 0;
  logic [35:0] fa_d1, fa_d2;
  logic        empty_a, rd_en_a, valid_a, err_a;
  logic [35:0] data_a;
  logic [1:0]  count_a;
  assign empty_a = (fa_rd == fa_wr);
  always_ff @(posedge clk) begin
    if (rd_en_a) begin
      fa_d1 <= fa_mem[fa_rd];
      fa_rd <= fa_rd + 1;
    end
    fa_d2 <= fa_d1;
  end

  // FIFO model B: one-cycle read latency
  logic [35:0] fb_mem [0:63];
  int          fb_wr = 0;
  int          fb_rd = 0;
  logic [35:0] fb_d1;
  logic        empty_b, rd_en_b, valid_b, err_b;
  logic [35:0] data_b;
  logic [1:0]  count_b;
  assign empty_b = (fb_rd == fb_wr);
  always_ff @(posedge clk) begin
    if (rd_en_b) begin
      fb_d1 <= fb_mem[fb_rd];
      fb_rd <= fb_rd + 1;
    end
  end

  fifo_stream_reader #(.WIDTH(36), .READ_LATENCY(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a),
    .fifo_empty_i(empty_a), .fifo_rderr_i(rderr_a), .fifo_dout_i(fa_d2),
    .fifo_rd_en_o(rd_en_a), .m_data_o(data_a), .m_valid_o(valid_a),
    .m_ready_i(ready_a), .count_o(count_a), .rd_err_o(err_a)
  );

  fifo_stream_reader #(.WIDTH(36), .READ_LATENCY(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
    .fifo_empty_i(empty_b), .fifo_rderr_i(1'b0), .fifo_dout_i(fb_d1),
    .fifo_rd_en_o(rd_en_b), .m_data_o(data_b), .m_valid_o(valid_b),
    .m_ready_i(ready_b), .count_o(count_b), .rd_err_o(err_b)
  );

  int n_vec = 0;
  int n_err = 0;

  int rd_cnt, rd_first, rd_last, v_cnt, v_first, v_last, max_c, max_cb;
  logic v0, held, last_v;
  logic [1:0] c0, last_c;
  logic [35:0] held_d, last_d;
  logic [35:0] rx_a [$];
  logic [35:0] rx_b [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [35:0] v);
    fa_mem[fa_wr] = v;
    fa_wr++;
  endtask

  task automatic push_b(input logic [35:0] v);
    fb_mem[fb_wr] = v;
    fb_wr++;
  endtask

  // Runs n cycles starting just after a clock edge, recording both streams.
  task automatic capture(input int n);
    rd_cnt = 0; rd_first = -1; rd_last = -1;
    v_cnt = 0; v_first = -1; v_last = -1;
    max_c = 0; max_cb = 0; held = 1'b1;
    rx_a.delete(); rx_b.delete();
    for (int i = 0; i < n; i++) begin
      if (tog_b) ready_b = (i % 2 == 0);
      #1;
      if (i == 0) begin v0 = valid_a; c0 = count_a; end
      if (rd_en_a) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = i;
        rd_last = i;
      end
      if (valid_a) begin
        v_cnt++;
        if (v_first < 0) begin v_first = i; held_d = data_a; end
        else if (!ready_a && data_a !== held_d) held = 1'b0;
        v_last = i;
        if (ready_a) rx_a.push_back(data_a);
      end
      if (valid_b && ready_b) rx_b.push_back(data_b);
      if (int'(count_a) > max_c) max_c = int'(count_a);
      if (int'(count_b) > max_cb) max_cb = int'(count_b);
      last_v = valid_a; last_c = count_a; last_d = data_a;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    #1;
    chk("rst_valid", valid_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_rden", rd_en_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // streaming with ready held high
    ready_a = 1'b1;
    for (int k = 1; k <= 8; k++) push_a(36'(k));
    capture(20);
    chk("t1_rd_cnt", rd_cnt, 8);
    chk("t1_rd_span", rd_last - rd_first, 7);
    chk("t1_first_lat", v_first - rd_first, 3);
    chk("t1_v_cnt", v_cnt, 8);
    chk("t1_v_span", v_last - v_first, 7);
    chk("t1_max_cnt", max_c, 1);
    chk("t1_rx_len", rx_a.size(), 8);
    for (int k = 0; k < 8 && k < rx_a.size(); k++) chk($sformatf("t1_word%0d", k), rx_a[k], 36'(k + 1));

    // backpressure then release
    ready_a = 1'b0;
    for (int k = 0; k < 8; k++) push_a(36'h21 + 36'(k));
    capture(10);
    chk("t2_rd_cnt", rd_cnt, 3);
    chk("t2_count", last_c, 3);
    chk("t2_valid", last_v, 1);
    chk("t2_data", last_d, 36'h21);
    chk("t2_held", held, 1);
    ready_a = 1'b1;
    capture(12);
    chk("t2_v_first", v_first, 0);
    chk("t2_v_cnt", v_cnt, 8);
    chk("t2_v_span", v_last, 7);
    chk("t2_rx_len", rx_a.size(), 8);
    for (int k = 0; k < 8 && k < rx_a.size(); k++) chk($sformatf("t2_word%0d", k), rx_a[k], 36'h21 + 36'(k));

    // latency 1 with alternating ready
    tog_b = 1'b1;
    for (int k = 0; k < 6; k++) push_b(36'h31 + 36'(k));
    capture(30);
    tog_b = 1'b0;
    ready_b = 1'b0;
    chk("t3_max_le2", (max_cb <= 2), 1);
    chk("t3_rx_len", rx_b.size(), 6);
    for (int k = 0; k < 6 && k < rx_b.size(); k++) chk($sformatf("t3_word%0d", k), rx_b[k], 36'h31 + 36'(k));

    // flush with two reads in flight
    push_a(36'hA); push_a(36'hB); push_a(36'hC);
    #1; chk("t4_rd0", rd_en_a, 1);
    @(posedge clk); #1;
    #1; chk("t4_rd1", rd_en_a, 1);
    @(posedge clk); #1;
    flush_a = 1'b1;
    #1; chk("t4_rd_gate", rd_en_a, 0);
    @(posedge clk); #1;
    flush_a = 1'b0;
    capture(12);
    chk("t4_valid_after", v0, 0);
    chk("t4_count_after", c0, 0);
    chk("t4_rx_len", rx_a.size(), 1);
    if (rx_a.size() > 0) chk("t4_word", rx_a[0], 36'hC);

    // empty FIFO, then sticky read error
    capture(20);
    chk("t5_rd_cnt", rd_cnt, 0);
    chk("t5_v_cnt", v_cnt, 0);
    rderr_a = 1'b1;
    @(posedge clk); #1;
    rderr_a = 1'b0;
    #1; chk("t5_err_set", err_a, 1);
    repeat (5) @(posedge clk);
    #1; chk("t5_err_sticky", err_a, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1; chk("t5_err_clr", err_a, 0);
    @(posedge clk); #1;

    // reset in mid-stream
    ready_a = 1'b0;
    for (int k = 0; k < 6; k++) push_a(36'h41 + 36'(k));
    capture(4);
    rst_n = 1'b0;
    #1; chk("t6_count_pre", count_a, 2);
    @(posedge clk); #1;
    #1;
    chk("t6_valid_rst", valid_a, 0);
    chk("t6_count_rst", count_a, 0);
    chk("t6_rden_rst", rd_en_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_a = 1'b1;
    capture(20);
    chk("t6_rx_len", rx_a.size(), 3);
    for (int k = 0; k < 3 && k < rx_a.size(); k++) chk($sformatf("t6_word%0d", k), rx_a[k], 36'h44 + 36'(k));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
